// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//   Run-control initiator for the program counter. Holds the PC in reset for
//   RST_CYCLES cycles after a start request, releases it for the run, ends the
//   run on a decoder halt or on the watchdog limit, pulses done, and then
//   advances the program index that selects the next run's start address.
//
// Parameters
//   RST_CYCLES  cycles pc_reset stays high in LOAD before the run (>= 1)
//   MAX_CYCLES  watchdog limit on RUN cycles (2..65535)
//
// Ports
//   CLK          in   clock, all state changes on posedge
//   reset        in   asynchronous active-low reset of the whole block
//   start        in   run request, sampled only in IDLE
//   halt         in   halt instruction seen by the decoder, used only in RUN
//   pc_reset     out  PC synchronous reset; low only while running
//   state        out  [1:0] program index selecting the PC start address
//   busy         out  high in LOAD and RUN
//   done         out  one-cycle completion pulse
//   timeout      out  last run ended by the watchdog; held until next start
//   cycle_count  out  [15:0] RUN cycles of the current/last run
// ---------------------------------------------------------------------------
module prog_sequencer #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  output logic        pc_reset,
  output logic [1:0]  state,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } fsm_t;

  localparam logic [15:0] LOAD_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] WD_LAST   = 16'(MAX_CYCLES - 1);

  fsm_t        r_fsm;
  fsm_t        w_fsm_nxt;
  logic [15:0] r_load_cnt;
  logic [15:0] r_cycle_cnt;
  logic        r_timeout;
  logic [1:0]  r_prog;
  logic        w_load_end;
  logic        w_wd_hit;

  assign w_load_end = (r_load_cnt == LOAD_LAST);
  assign w_wd_hit   = (r_cycle_cnt == WD_LAST);

  // FSM state register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Next-state logic; halt takes priority over the watchdog
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: if (start)               w_fsm_nxt = S_LOAD;
      S_LOAD: if (w_load_end)          w_fsm_nxt = S_RUN;
      S_RUN:  if (halt || w_wd_hit)    w_fsm_nxt = S_DONE;
      S_DONE:                          w_fsm_nxt = S_IDLE;
      default:                         w_fsm_nxt = S_IDLE;
    endcase
  end

  // Counters, timeout flag and program index
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_load_cnt  <= '0;
      r_cycle_cnt <= '0;
      r_timeout   <= 1'b0;
      r_prog      <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (start) begin
            r_load_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
          end
        end
        S_LOAD: r_load_cnt <= r_load_cnt + 16'd1;
        S_RUN: begin
          // Counts the exit edge too, so a watchdog exit reports MAX_CYCLES.
          r_cycle_cnt <= r_cycle_cnt + 16'd1;
          if (!halt && w_wd_hit) r_timeout <= 1'b1;
        end
        S_DONE: r_prog <= r_prog + 2'd1;
        default: ;
      endcase
    end
  end

  // Outputs decoded straight from the FSM so an async reset shows at once
  assign pc_reset    = (r_fsm != S_RUN);
  assign busy        = (r_fsm == S_LOAD) || (r_fsm == S_RUN);
  assign done        = (r_fsm == S_DONE);
  assign state       = r_prog;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

  logic        CLK;
  logic        reset;
  logic        start;
  logic        halt;
  logic        pc_reset;
  logic [1:0]  state;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  int n_checks;
  int n_fail;
  logic [1:0] exp_state;

  prog_sequencer #(
    .RST_CYCLES(2),
    .MAX_CYCLES(20)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .halt       (halt),
    .pc_reset   (pc_reset),
    .state      (state),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .cycle_count(cycle_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // From IDLE: one run lasting n_run RUN cycles, ended by halt.
  // noisy=1 adds start pulses inside LOAD/RUN and a halt pulse in IDLE.
  task automatic do_run(input int n_run, input bit noisy);
    start = 1'b1;
    tick();
    start = noisy;
    chk_val("load_busy", busy, 1);
    chk_val("load_pcrst", pc_reset, 1);
    chk_val("load_cnt_clr", cycle_count, 0);
    chk_val("load_to_clr", timeout, 0);
    tick();
    start = 1'b0;
    chk_val("load2_pcrst", pc_reset, 1);
    tick();
    chk_val("run_pcrst", pc_reset, 0);
    chk_val("run_busy", busy, 1);
    for (int i = 1; i < n_run; i++) begin
      start = noisy && (i == 1);
      tick();
    end
    start = 1'b0;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk_val("done_hi", done, 1);
    chk_val("done_cnt", cycle_count, n_run);
    chk_val("done_to", timeout, 0);
    chk_val("done_pcrst", pc_reset, 1);
    chk_val("done_state_hold", state, exp_state);
    tick();
    exp_state = exp_state + 2'd1;
    chk_val("idle_done_lo", done, 0);
    chk_val("idle_busy", busy, 0);
    chk_val("idle_state", state, exp_state);
    if (noisy) begin
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk_val("idle_halt_busy", busy, 0);
      chk_val("idle_halt_cnt", cycle_count, n_run);
      tick();
      chk_val("idle_stay", busy, 0);
      chk_val("idle_no_done", done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_state = 2'd0;
    reset = 1'b0;
    start = 1'b0;
    halt  = 1'b0;

    // Reset then idle
    repeat (3) tick();
    chk_val("rst_pcrst", pc_reset, 1);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_state", state, 0);
    chk_val("rst_cnt", cycle_count, 0);
    chk_val("rst_to", timeout, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_val("idle_pcrst", pc_reset, 1);
      chk_val("idle_busy0", busy | done, 0);
      chk_val("idle_state0", {14'd0, state} | cycle_count, 0);
    end

    // Normal run: halt in 5th RUN cycle
    do_run(5, 1'b0);

    // Watchdog without halt: DONE after 20 RUN cycles
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_val("wd_run", pc_reset, 0);
    repeat (19) tick();
    chk_val("wd_pre_busy", busy, 1);
    chk_val("wd_pre_cnt", cycle_count, 19);
    chk_val("wd_pre_to", timeout, 0);
    tick();
    chk_val("wd_done", done, 1);
    chk_val("wd_cnt", cycle_count, 20);
    chk_val("wd_to", timeout, 1);
    tick();
    exp_state = exp_state + 2'd1;
    chk_val("wd_idle_state", state, exp_state);
    repeat (2) tick();
    chk_val("wd_hold_to", timeout, 1);
    chk_val("wd_hold_cnt", cycle_count, 20);

    // Watchdog with halt in the same final cycle: halt wins
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_val("wdh_to_clr", timeout, 0);
    chk_val("wdh_cnt_clr", cycle_count, 0);
    tick();
    tick();
    repeat (19) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk_val("wdh_done", done, 1);
    chk_val("wdh_cnt", cycle_count, 20);
    chk_val("wdh_to", timeout, 0);
    tick();
    exp_state = exp_state + 2'd1;
    chk_val("wdh_state", state, exp_state);

    // State wrap with start/halt filtering, from a fresh reset
    #2 reset = 1'b0;
    #1 exp_state = 2'd0;
    chk_val("wrap_rst_state", state, 0);
    tick();
    reset = 1'b1;
    tick();
    for (int r = 0; r < 4; r++) do_run(2 + r, 1'b1);
    chk_val("wrap_state", state, 0);

    // Reset mid-RUN with state=2 and cycle_count=7
    do_run(1, 1'b0);
    do_run(1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    repeat (7) tick();
    chk_val("mid_state", state, 2);
    chk_val("mid_cnt", cycle_count, 7);
    chk_val("mid_pcrst_lo", pc_reset, 0);
    #2 reset = 1'b0;
    #1;
    chk_val("async_pcrst", pc_reset, 1);
    chk_val("async_busy", busy, 0);
    chk_val("async_state", state, 0);
    chk_val("async_cnt", cycle_count, 0);
    chk_val("async_done", done, 0);
    repeat (2) begin
      tick();
      chk_val("async_no_done", done, 0);
    end
    reset = 1'b1;
    exp_state = 2'd0;
    tick();

    // Held start: 3 runs, halt in 3rd RUN cycle, period 7 cycles
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      halt = ((c % 7) == 5);
      chk_val("held_done", done, ((c % 7) == 6));
      chk_val("held_busy", busy, ((c % 7) >= 1 && (c % 7) <= 5));
      if (c == 21) start = 1'b0;
    end
    halt = 1'b0;
    tick();
    chk_val("held_state", state, 3);
    chk_val("held_idle", busy, 0);
    chk_val("held_cnt", cycle_count, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Run-control initiator that drives the program counter's synchronous `reset` and 2-bit `state` inputs. It sequences program runs: hold PC in reset, release it, watch for halt or watchdog timeout, then report completion. It sits between the bench/top-level start/done handshake and the fetch datapath. It owns the `state` index that selects each program's start address in the PC.

Parameters:
RST_CYCLES, 2, number of cycles `pc_reset` is held high after `start` before the run begins (≥1)
MAX_CYCLES, 1000, watchdog limit on RUN cycles (2..65535)

Ports:
CLK  input  1  clock; all state changes on posedge
reset  input  1  asynchronous, active-low reset of the whole block
start  input  1  request a program run; sampled only in IDLE
halt  input  1  decoder flags a halt instruction this cycle; honoured only in RUN
pc_reset  output  1  to PC `reset`; high holds PC at its start address
state  output  2  to PC `state`; program index selecting start address
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle completion pulse
timeout  output  1  high if last run ended by watchdog; held until next start
cycle_count  output  16  RUN cycles of the current or last run; held until next start

Behaviour:
- FSM states: IDLE, LOAD, RUN, DONE. All registers are async-cleared when `reset`=0.
- Values while reset is active: FSM=IDLE, state=0, cycle_count=0, timeout=0, load counter=0, done=0, busy=0, pc_reset=1.
- Output decode from FSM:
  - `pc_reset` = 1 in every FSM state except RUN.
  - busy = (LOAD|RUN).
  - done = (DONE).
- IDLE:
  - start=1 at an edge → LOAD next cycle.
  - On that edge: cycle_count←0, timeout←0, load counter←0.
  - start=0 → stay in IDLE.
- LOAD:
  - Load counter increments each cycle.
  - When counter == RST_CYCLES-1 → RUN next edge.
  - LOAD therefore lasts exactly RST_CYCLES cycles.
  - state is stable throughout LOAD, so the PC loads the correct start address.
- RUN:
  - cycle_count increments by 1 at every edge while in RUN, including the exit edge.
  - halt=1 → DONE; timeout stays 0.
  - Else if cycle_count == MAX_CYCLES-1 → DONE; timeout←1 on the same edge.
  - halt and watchdog in the same cycle: halt wins; timeout=0 and cycle_count = MAX_CYCLES.
- DONE:
  - Lasts exactly one cycle → IDLE.
  - On the DONE→IDLE edge: state ← state+1 mod 4 (3 wraps to 0).
  - cycle_count and timeout are held.
- Ignored inputs:
  - start outside IDLE is ignored; no queuing. A start held high through DONE is accepted in the following IDLE cycle.
  - halt outside RUN is ignored.
- Async reset in any state (including mid-RUN) returns immediately to the reset values.
  - state returns to 0; no done pulse is produced.
  - pc_reset goes high combinationally from the async-cleared FSM.
- Arithmetic:
  - cycle_count is 16-bit unsigned.
  - It cannot overflow, because the watchdog fires at or below 65535.
- Latency:
  - start edge to first RUN cycle = RST_CYCLES+1 cycles from the start sample.
  - halt edge to done high = 1 cycle.
  - done to ready for next start = 1 cycle.

Test Plan:
- Reset then idle: `reset` low 3 cycles then high, start=0 for 10 cycles → pc_reset=1, state=0, busy=0, done=0, cycle_count=0 throughout.
- Normal run (RST_CYCLES=2): start pulse at edge 0 → busy=1 with pc_reset=1 for 2 cycles, then pc_reset=0; halt asserted in 5th RUN cycle → done=1 one cycle later for exactly 1 cycle, cycle_count=5, timeout=0, then state=1.
- Watchdog (MAX_CYCLES=20): start, never assert halt → DONE after 20 RUN cycles, cycle_count=20, timeout=1; halt=1 in the same final cycle instead → timeout=0, cycle_count=20.
- State wrap and start filtering: four back-to-back runs → state 0→1→2→3→0; extra start pulses during LOAD/RUN produce no extra runs; halt pulses in IDLE have no effect.
- Reset mid-operation: assert `reset` low asynchronously mid-RUN with state=2 and cycle_count=7 → pc_reset=1, busy=0, state=0, cycle_count=0 without waiting for a clock edge; no done pulse.
- Held start: start held high continuously for 3 runs with halt after 3 RUN cycles each → each run re-enters LOAD after one IDLE cycle, done pulses spaced RST_CYCLES+3+2 cycles apart, state increments each run.
